mem_stage_access_unit: RTL and testbench

//  MEM-stage data-memory access controller. Sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_stage_access_unit_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 42 ++++
 rtl/mem_stage_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_unit_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encodings, the default timeout load word and a decode helper.
package mem_stage_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

  // An instruction needs the data-memory port when it is valid and is a load or a store.
  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait timer for the ACCESS state. Cleared outside ACCESS, counts while enabled,
// and flags expiry once the count reaches MAX_WAIT-1 (the last allowed wait cycle).
module mem_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == LAST_CNT);

  // Next count: clear wins, otherwise count up and hold once expired.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access controller. Non-memory instructions pass through
// with zero latency; loads/stores stall the upstream pipeline, run one req/ack
// transaction on the data-memory port (bounded by a wait timer) and then present
// the result to MEM/WB for exactly one cycle.
module mem_stage_access_unit
  import mem_stage_access_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MAX_WAIT   = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_WORD   = DATA_WIDTH'(ERR_WORD_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_Valid,
  input  logic                  in_CtrlMemRead,
  input  logic                  in_CtrlMemWrite,
  input  logic [DATA_WIDTH-1:0] in_ALUResult,
  input  logic [DATA_WIDTH-1:0] in_WriteData,
  output logic                  out_Stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [DATA_WIDTH-1:0] out_MemoryData,
  output logic                  out_Valid,
  output logic                  out_MemError
);

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  acc_s;
  logic                  timer_clear_s;
  logic                  timer_en_s;
  logic                  timer_expired_s;
  logic                  stall_s;
  logic                  req_s;
  logic                  out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic                  out_err_s;

  assign acc_s = is_mem_op(in_Valid, in_CtrlMemRead, in_CtrlMemWrite);

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (timer_expired_s)
  );

  // FSM next state, request latches and MEM/WB output muxing.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    valid_d       = valid_q;
    data_d        = data_q;
    err_d         = err_q;
    timer_clear_s = 1'b1;
    timer_en_s    = 1'b0;
    stall_s       = 1'b0;
    req_s         = 1'b0;
    out_valid_s   = 1'b0;
    out_data_s    = {DATA_WIDTH{1'b0}};
    out_err_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc_s) begin
          // Capture the request; write wins when both read and write are set.
          stall_s = 1'b1;
          state_d = ST_ACCESS;
          addr_d  = in_ALUResult[ADDR_WIDTH-1:0];
          wdata_d = in_WriteData;
          we_d    = in_CtrlMemWrite;
          valid_d = in_Valid;
          data_d  = {DATA_WIDTH{1'b0}};
          err_d   = 1'b0;
        end else begin
          out_valid_s = in_Valid;
        end
      end

      ST_ACCESS: begin
        req_s         = 1'b1;
        stall_s       = 1'b1;
        timer_clear_s = 1'b0;
        timer_en_s    = 1'b1;
        // A flush while stalled kills the result but not the bus transaction.
        valid_d       = valid_q & in_Valid;
        if (mem_ack) begin
          data_d  = we_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (timer_expired_s) begin
          data_d  = we_q ? {DATA_WIDTH{1'b0}} : ERR_WORD;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCESS;
        end
      end

      ST_DONE: begin
        out_valid_s = valid_q;
        out_data_s  = data_q;
        out_err_s   = err_q;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request/result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign out_Stall      = stall_s;
  assign mem_req        = req_s;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign out_Valid      = out_valid_s;
  assign out_MemoryData = out_data_s;
  assign out_MemError   = out_err_s;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed bench for mem_stage_access_unit with a result scoreboard.
module tb_mem_stage_access_unit;

  localparam int MAX_WAIT = 16;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        err;
    int          req_cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_Valid;
  logic        in_CtrlMemRead;
  logic        in_CtrlMemWrite;
  logic [31:0] in_ALUResult;
  logic [31:0] in_WriteData;
  logic        out_Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] out_MemoryData;
  logic        out_Valid;
  logic        out_MemError;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  mem_stage_access_unit #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MAX_WAIT   (MAX_WAIT),
    .ERR_WORD   (32'hDEAD_BEEF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_Valid        (in_Valid),
    .in_CtrlMemRead  (in_CtrlMemRead),
    .in_CtrlMemWrite (in_CtrlMemWrite),
    .in_ALUResult    (in_ALUResult),
    .in_WriteData    (in_WriteData),
    .out_Stall       (out_Stall),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .out_MemoryData  (out_MemoryData),
    .out_Valid       (out_Valid),
    .out_MemError    (out_MemError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    in_Valid        = 1'b0;
    in_CtrlMemRead  = 1'b0;
    in_CtrlMemWrite = 1'b0;
    mem_ack         = 1'b0;
  endtask

  // Non-memory instruction: result must appear in the same cycle. Called at #1 after a posedge.
  task automatic alu_op(input logic v, input logic [31:0] alu);
    exp_t e;
    e.valid = v; e.data = 32'h0; e.err = 1'b0; e.req_cycles = 0;
    exp_q.push_back(e);
    in_Valid = v; in_CtrlMemRead = 1'b0; in_CtrlMemWrite = 1'b0; in_ALUResult = alu;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("alu_valid", out_Valid, e.valid);
    chk("alu_data", out_MemoryData, e.data);
    chk("alu_stall", out_Stall, 1'b0);
    chk("alu_req", mem_req, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Memory op: ack_at = ACCESS-cycle index of the ack (-1 = never), flush_at = ACCESS-cycle
  // index from which in_Valid is dropped (-1 = never). Called at #1 after a posedge in IDLE.
  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input int ack_at, input int flush_at);
    exp_t e;
    int   last;
    logic timed_out;
    int   k;
    int   req_cycles;
    logic done;
    timed_out = !(ack_at >= 0 && ack_at < MAX_WAIT);
    last      = timed_out ? MAX_WAIT - 1 : ack_at;
    e.valid      = !(flush_at >= 0 && flush_at <= last);
    e.data       = wr ? 32'h0 : (timed_out ? 32'hDEAD_BEEF : rdata);
    e.err        = timed_out;
    e.req_cycles = last + 1;
    exp_q.push_back(e);

    in_Valid = 1'b1; in_CtrlMemRead = rd; in_CtrlMemWrite = wr;
    in_ALUResult = addr; in_WriteData = wd; mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_stall", out_Stall, 1'b1);
    chk("idle_req", mem_req, 1'b0);
    chk("idle_valid", out_Valid, 1'b0);

    k = 0; req_cycles = 0; done = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      in_Valid  = (flush_at >= 0 && k >= flush_at) ? 1'b0 : 1'b1;
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rdata : $urandom;
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        chk("acc_addr", mem_addr, addr);
        chk("acc_wdata", mem_wdata, wd);
        chk("acc_we", mem_we, wr);
        chk("acc_stall", out_Stall, 1'b1);
      end else if (!out_Stall) begin
        done = 1'b1;
      end else begin
        done = 1'b0;
      end
      k++;
    end
    chk("done_seen", done, 1'b1);
    e = exp_q.pop_front();
    chk("done_valid", out_Valid, e.valid);
    chk("done_data", out_MemoryData, e.data);
    chk("done_err", out_MemError, e.err);
    chk("req_cycles", req_cycles, e.req_cycles);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    in_ALUResult = 32'h0; in_WriteData = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", out_Stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", out_Valid, 1'b0);
    chk("rst_data", out_MemoryData, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1. Reset in the middle of an access
    in_Valid = 1'b1; in_CtrlMemRead = 1'b1; in_ALUResult = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", mem_req, 1'b1);
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("async_req", mem_req, 1'b0);
    chk("async_stall", out_Stall, 1'b0);
    chk("async_addr", mem_addr, 32'h0);
    chk("async_we", mem_we, 1'b0);
    chk("async_valid", out_Valid, 1'b0);
    chk("async_err", out_MemError, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("late_ack_req", mem_req, 1'b0);
    chk("late_ack_valid", out_Valid, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    alu_op(1'b1, 32'h0000_0042);

    // 2. Load, same-cycle ack
    mem_op(1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0, -1);
    // 3. Store, ack after 4 cycles
    mem_op(1'b0, 1'b1, 32'h200, 32'h0000_CAFE, 32'hFFFF_FFFF, 3, -1);
    // 4. Load timeout, then ack on the last allowed cycle
    mem_op(1'b1, 1'b0, 32'h400, 32'h0, 32'h0BAD_F00D, -1, -1);
    mem_op(1'b1, 1'b0, 32'h404, 32'h0, 32'h0BAD_F00D, MAX_WAIT - 1, -1);
    // Store timeout: error set, data zero; read+write behaves as a store
    mem_op(1'b0, 1'b1, 32'h500, 32'h1111_2222, 32'h0, -1, -1);
    mem_op(1'b1, 1'b1, 32'h504, 32'h3333_4444, 32'h7777_8888, 1, -1);
    // 5. ALU pass-through, valid and bubble
    alu_op(1'b1, 32'h0000_0010);
    alu_op(1'b0, 32'h0000_0020);
    // 6. Back-to-back loads, flush during the second ACCESS
    mem_op(1'b1, 1'b0, 32'h600, 32'h0, 32'hA5A5_0001, 0, -1);
    mem_op(1'b1, 1'b0, 32'h604, 32'h0, 32'hA5A5_0002, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
